// File: rtl/pin_bus_pkg.sv
// Shared types and constants for the pin bus responder.
// State encoding, register map addresses and widths.
package pin_bus_pkg;

    localparam int REG_W  = 8;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_ID  = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_CNT = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        RELEASE
    } state_t;

    // Registers 0 and 15 cannot be written by the host.
    function automatic logic is_ro(input logic [ADDR_W-1:0] a);
        return (a == ADDR_ID) || (a == ADDR_CNT);
    endfunction

endpackage

// File: rtl/pin_bus_responder_if.sv
// Four-phase parallel pin bus between host and responder.
// master: req/rnw/addr/wdata out; slave: ack/err/rdata/rdata_oe out.
interface pin_bus_responder_if;
    import pin_bus_pkg::*;

    logic              req_i;
    logic              rnw_i;
    logic [ADDR_W-1:0] addr_i;
    logic [REG_W-1:0]  wdata_i;
    logic              ack_o;
    logic              err_o;
    logic [REG_W-1:0]  rdata_o;
    logic [REG_W-1:0]  rdata_oe_o;

    modport master (
        output req_i, rnw_i, addr_i, wdata_i,
        input  ack_o, err_o, rdata_o, rdata_oe_o
    );

    modport slave (
        input  req_i, rnw_i, addr_i, wdata_i,
        output ack_o, err_o, rdata_o, rdata_oe_o
    );

endinterface

// File: rtl/pin_bus_responder_sync.sv
// Multi-flop synchroniser, reset to 0.
// Ports: clk, rst (sync, active high), d (async in), q (synchronised out).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pin_bus_responder.sv
// Target side of the four-phase pin bus with a 16x8 register file.
// Ports: clk, rst (sync, active high), ena, bus (slave modport).
module pin_bus_responder
    import pin_bus_pkg::*;
#(
    parameter logic [REG_W-1:0] ID_VALUE    = 8'hA5,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    pin_bus_responder_if.slave  bus
);

    state_t            state;
    logic              req_s;
    logic [ADDR_W-1:0] addr_q;
    logic              rnw_q;
    logic [REG_W-1:0]  wdata_q;
    logic [REG_W-1:0]  cnt;
    logic [REG_W-1:0]  regs [16];
    logic [REG_W-1:0]  rd_val;
    logic              ack_q;
    logic              err_q;
    logic [REG_W-1:0]  rdata_q;
    logic [REG_W-1:0]  oe_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.req_i),
        .q   (req_s)
    );

    // The counter bumps on the same edge that loads rdata, so a read
    // of 15 returns the count including itself.
    always_comb begin
        rd_val = regs[addr_q];
        if (addr_q == ADDR_ID) begin
            rd_val = ID_VALUE;
        end else if (addr_q == ADDR_CNT) begin
            rd_val = cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            wdata_q <= '0;
            cnt     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            oe_q    <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_s && ena) begin
                        addr_q  <= bus.addr_i;
                        rnw_q   <= bus.rnw_i;
                        wdata_q <= bus.wdata_i;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (rnw_q) begin
                        rdata_q <= rd_val;
                    end else if (is_ro(addr_q)) begin
                        err_q <= 1'b1;
                    end else begin
                        regs[addr_q] <= wdata_q;
                    end
                    cnt   <= cnt + 8'd1;
                    ack_q <= 1'b1;
                    oe_q  <= {REG_W{rnw_q}};
                    state <= ACK;
                end
                ACK: begin
                    if (!req_s) begin
                        ack_q <= 1'b0;
                        oe_q  <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o      = ack_q;
    assign bus.err_o      = err_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.rdata_oe_o = oe_q;

endmodule
